// File: rtl/controle_decadico_pkg.sv
// Shared types and BCD helpers for the decade-counter run controller.
// Pure declarations, no logic of its own.
package controle_decadico_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] n);
        return n <= BCD_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/controle_decadico_if.sv
// Control/status bundle between the board controller and the decade sequencer.
// Levels only, no handshake; outputs are registered by the sequencer.
interface controle_decadico_if #(parameter int DIGITS = 2);
    logic                  start;
    logic                  stop;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   limit;
    logic [4*DIGITS-1:0]   s;
    logic                  running;
    logic                  done;
    logic                  err;

    modport master (
        output start, stop, load, load_val, limit,
        input  s, running, done, err
    );

    modport slave (
        input  start, stop, load, load_val, limit,
        output s, running, done, err
    );
endinterface

// File: rtl/controle_decadico_decade_stage.sv
// One BCD digit: synchronous clear, parallel load, mod-10 increment when enabled.
// Single-cycle update; carry_out is combinational from en and q.
module decade_stage
    import controle_decadico_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             ld,
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q,
    output logic             carry_out
);
    logic [BCD_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (clear)
            r_q <= '0;
        else if (ld)
            r_q <= d;
        else if (en)
            r_q <= (r_q == BCD_W'(BCD_MAX)) ? '0 : r_q + BCD_W'(1);
    end

    assign q         = r_q;
    assign carry_out = en & (r_q == BCD_W'(BCD_MAX));
endmodule

// File: rtl/controle_decadico.sv
// Run/pause/preset sequencer over a chain of decade stages with BCD terminal compare.
// All outputs registered; a load with any invalid nibble freezes the cycle and sets err.
module controle_decadico
    import controle_decadico_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                 clk,
    input  logic                 clear,
    controle_decadico_if.slave   io_ctl
);
    localparam int W = BCD_W * DIGITS;

    state_t         r_state, w_state_nxt;
    logic           r_running, r_done, r_err;
    logic [W-1:0]   w_s, w_d;
    logic           w_ld_vld, w_lim_vld, w_load_ok, w_load_bad;
    logic           w_term, w_inc, w_ld, w_done_nxt;
    logic [DIGITS:0] w_carry;

    always_comb begin
        w_ld_vld  = 1'b1;
        w_lim_vld = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(io_ctl.load_val[i*BCD_W +: BCD_W])) w_ld_vld  = 1'b0;
            if (!bcd_valid(io_ctl.limit[i*BCD_W +: BCD_W]))    w_lim_vld = 1'b0;
        end
    end

    assign w_load_ok  = io_ctl.load &  w_ld_vld;
    assign w_load_bad = io_ctl.load & ~w_ld_vld;
    // An invalid limit disables the compare so the chain free-runs through all-9s.
    assign w_term     = w_lim_vld && (w_s == io_ctl.limit);

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_ld        = 1'b0;
        w_d         = '0;
        w_done_nxt  = 1'b0;
        if (w_load_bad) begin
            w_state_nxt = r_state;
        end else if (w_load_ok) begin
            w_ld        = 1'b1;
            w_d         = io_ctl.load_val;
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                RUN: begin
                    if (io_ctl.stop) begin
                        w_state_nxt = PAUSE;
                    end else if (w_term) begin
                        w_ld        = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = AUTO_RELOAD ? RUN : DONE;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
                IDLE, PAUSE, DONE: begin
                    if (!io_ctl.stop && io_ctl.start) w_state_nxt = RUN;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == RUN);
            r_done    <= w_done_nxt;
            r_err     <= r_err | w_load_bad | ~w_lim_vld;
        end
    end

    assign w_carry[0] = w_inc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        decade_stage u_stage (
            .clk       (clk),
            .clear     (clear),
            .en        (w_carry[g]),
            .ld        (w_ld),
            .d         (w_d[g*BCD_W +: BCD_W]),
            .q         (w_s[g*BCD_W +: BCD_W]),
            .carry_out (w_carry[g+1])
        );
    end

    assign io_ctl.s       = w_s;
    assign io_ctl.running = r_running;
    assign io_ctl.done    = r_done;
    assign io_ctl.err     = r_err;
endmodule

// File: tb/tb_controle_decadico.sv
// Directed bench: dut0 stops at terminal count, dut1 auto-reloads; both 2 digits.
module tb_controle_decadico;
    logic clk = 1'b0;
    logic clear0, clear1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    controle_decadico_if #(.DIGITS(2)) bus0 ();
    controle_decadico_if #(.DIGITS(2)) bus1 ();

    controle_decadico #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .clear(clear0), .io_ctl(bus0)
    );
    controle_decadico #(.DIGITS(2), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .clear(clear1), .io_ctl(bus1)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk0(input string tag, input logic [7:0] s, input logic run, input logic dn);
        chk({tag, ".s"},       16'(bus0.s),       16'(s));
        chk({tag, ".running"}, 16'(bus0.running), 16'(run));
        chk({tag, ".done"},    16'(bus0.done),    16'(dn));
    endtask

    task automatic chk1(input string tag, input logic [7:0] s, input logic run, input logic dn);
        chk({tag, ".s"},       16'(bus1.s),       16'(s));
        chk({tag, ".running"}, 16'(bus1.running), 16'(run));
        chk({tag, ".done"},    16'(bus1.done),    16'(dn));
    endtask

    logic [7:0] seq1 [6];

    initial begin
        clear0 = 1'b1; clear1 = 1'b1;
        bus0.start = 1'b1; bus0.stop = 1'b0; bus0.load = 1'b0;
        bus0.load_val = 8'h00; bus0.limit = 8'h09;
        bus1.start = 1'b0; bus1.stop = 1'b0; bus1.load = 1'b0;
        bus1.load_val = 8'h00; bus1.limit = 8'h02;

        // reset with start held high
        tick(2);
        chk0("reset", 8'h00, 1'b0, 1'b0);
        chk("reset.err", 16'(bus0.err), 16'h0);

        // basic run to limit 09
        clear0 = 1'b0;
        tick();
        chk0("start", 8'h00, 1'b1, 1'b0);
        bus0.start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk0($sformatf("count%0d", i), 8'(i), 1'b1, 1'b0);
        end
        tick();
        chk0("term", 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk0($sformatf("done_hold%0d", i), 8'h00, 1'b0, 1'b0);
        end

        // carry across digits: 19 -> 25 -> 00
        bus0.load = 1'b1; bus0.load_val = 8'h19; bus0.limit = 8'h25;
        tick();
        chk0("load19", 8'h19, 1'b0, 1'b0);
        bus0.load = 1'b0; bus0.start = 1'b1;
        tick();
        chk0("run19", 8'h19, 1'b1, 1'b0);
        bus0.start = 1'b0;
        tick();
        chk0("carry20", 8'h20, 1'b1, 1'b0);
        tick(5);
        chk0("reach25", 8'h25, 1'b1, 1'b0);
        tick();
        chk0("term25", 8'h00, 1'b0, 1'b1);

        // pause and resume
        bus0.limit = 8'h50; bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        tick(5);
        chk0("pre_pause", 8'h05, 1'b1, 1'b0);
        bus0.stop = 1'b1;
        tick();
        chk0("pause", 8'h05, 1'b0, 1'b0);
        tick(2);
        chk0("pause_hold", 8'h05, 1'b0, 1'b0);
        bus0.stop = 1'b0; bus0.start = 1'b1;
        tick();
        chk0("resume", 8'h05, 1'b1, 1'b0);
        bus0.start = 1'b0;
        tick();
        chk0("resume_inc", 8'h06, 1'b1, 1'b0);
        bus0.stop = 1'b1; bus0.start = 1'b1;
        tick();
        chk0("stop_start", 8'h06, 1'b0, 1'b0);
        bus0.stop = 1'b0; bus0.start = 1'b0;

        // invalid preset is dropped and sets err
        chk("err_pre", 16'(bus0.err), 16'h0);
        bus0.load = 1'b1; bus0.load_val = 8'h3A;
        tick();
        chk0("bad_load", 8'h06, 1'b0, 1'b0);
        chk("bad_load.err", 16'(bus0.err), 16'h1);

        // invalid limit: free-run through 99 -> 00 without done
        bus0.load_val = 8'h97; bus0.limit = 8'h0F;
        tick();
        chk0("load97", 8'h97, 1'b0, 1'b0);
        bus0.load = 1'b0; bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        tick(); chk0("free98", 8'h98, 1'b1, 1'b0);
        tick(); chk0("free99", 8'h99, 1'b1, 1'b0);
        tick(); chk0("free00", 8'h00, 1'b1, 1'b0);
        tick(); chk0("free01", 8'h01, 1'b1, 1'b0);
        chk("err_sticky", 16'(bus0.err), 16'h1);
        clear0 = 1'b1; bus0.limit = 8'h09;
        tick();
        chk0("clear", 8'h00, 1'b0, 1'b0);
        chk("clear.err", 16'(bus0.err), 16'h0);

        // auto-reload, limit 02
        clear1 = 1'b0; bus1.start = 1'b1;
        tick();
        chk1("ar_start", 8'h00, 1'b1, 1'b0);
        bus1.start = 1'b0;
        seq1[0] = 8'h01; seq1[1] = 8'h02; seq1[2] = 8'h00;
        seq1[3] = 8'h01; seq1[4] = 8'h02; seq1[5] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk1($sformatf("ar%0d", i), seq1[i], 1'b1, (i == 2 || i == 5));
        end
        tick(2);
        chk1("ar_pre_clear", 8'h02, 1'b1, 1'b0);
        clear1 = 1'b1;
        tick();
        chk1("ar_clear", 8'h00, 1'b0, 1'b0);
        tick();
        chk1("ar_clear_hold", 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/controle_decadico.md
# controle_decadico

Run-control sequencer for a chain of cascaded decade (BCD, mod-10) counter stages. It starts, pauses, presets and terminates the count against a programmable BCD limit, and flags the terminal count. It is the control layer above the single-digit decade counters, for multi-digit counting experiments on the board.

## Interface
- DIGITS, 2, number of cascaded BCD digits (1..4)
- AUTO_RELOAD, 0, 0 = stop in DONE at terminal count; 1 = wrap and keep counting
- clk  in  1  system clock; all state changes on its rising edge
- clear  in  1  reset, synchronous and active-high
- start  in  1  level; enter or resume RUN
- stop  in  1  level; RUN -> PAUSE
- load  in  1  level; preset count from load_val
- load_val  in  4*DIGITS  BCD preset; digit 0 in bits [3:0]
- limit  in  4*DIGITS  BCD terminal value, sampled every cycle
- s  out  4*DIGITS  current BCD count; digit 0 in bits [3:0]
- running  out  1  high while state is RUN
- done  out  1  one-cycle terminal-count pulse
- err  out  1  sticky invalid-BCD flag

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset (clear=1): state IDLE, s=0, running=0, done=0, err=0. clear overrides every other input.
- Input priority below clear: load > stop > start.
- IDLE:
  - load: s<=load_val, stay in IDLE.
  - start: go to RUN. s is unchanged on that edge.
- RUN: on each edge s increments by 1 in BCD.
  - A digit at 9 becomes 0 and carries into the next digit.
  - All-9s wraps to 0.
  - Terminal: if s==limit at the edge, s<=0 and done<=1 for that edge.
    - AUTO_RELOAD=0: go to DONE.
    - AUTO_RELOAD=1: stay in RUN.
  - stop: go to PAUSE with s held, no increment on that edge. stop+start together also go to PAUSE.
  - load: s<=load_val, go to IDLE.
- PAUSE:
  - Hold s.
  - start: return to RUN.
  - load: preset s, go to IDLE.
- DONE:
  - s holds 0.
  - start: go to RUN.
  - load: preset s, go to IDLE.
- Invalid BCD (any nibble >9):
  - In load_val while load=1: the load is ignored entirely (s and state unchanged) and err<=1.
  - In limit: err<=1 and the terminal comparison is disabled, so the counter free-runs with all-9s wrap.
  - err stays set until clear.
- Preset above limit: the count runs up to all-9s, wraps to 0, and terminates only on equality with limit.
- limit=0 in RUN: every increment out of 0 is skipped. s stays 0, done pulses every cycle (AUTO_RELOAD=1), or enters DONE immediately.

## Timing
- All outputs are registered. running and done are decoded from registered next state, not combinationally from inputs.
- start sampled at edge k: running=1 after k; first increment at edge k+1.
- done is high for exactly one cycle, coincident with the first cycle s reads 0 after the terminal.
- With s=0 at start, the terminal count is reached limit+1 increments after the first RUN edge.
- stop sampled at edge k: s after k equals s before k.
- load preset is visible the cycle after the sampling edge.
- clear mid-run: all outputs are at reset values after the edge; no done pulse is generated.

## Structure
- Shared package holds:
  - state enum {IDLE, RUN, PAUSE, DONE}
  - BCD_W=4 and BCD_MAX=9 constants
  - a BCD-nibble-valid function
- Sub-module decade_stage (one per digit, generate loop):
  - Inputs: clk, clear, en, ld, d[3:0].
  - Outputs: q[3:0], carry_out = en & (q==9).
  - en of digit i = RUN increment enable AND carry_out of digit i-1.
- Top level holds the FSM, the limit comparator, the err logic and the done register.

## Test plan
- Reset: hold clear 2 cycles with start=1 -> s=00, running=0, done=0, err=0.
- Basic run, DIGITS=2, limit=09, start pulse: s counts 00..09, then reads 00 with done=1 for one cycle. DONE state, running=0, s stays 00 for 5 idle cycles.
- Carry: load 19, limit=25, start -> 20 on the first increment, 25 after 6 increments, then 00 with done=1.
- Pause: stop when s=05, hold 3 cycles -> s stays 05, running=0. start -> s=06 on the following edge. Assert stop+start together in RUN -> PAUSE.
- Invalid BCD: load 3A -> s unchanged, err=1. limit=0F -> no done, wrap 99->00. clear -> err=0.
- AUTO_RELOAD=1, limit=02: s sequence 00,01,02,00(done),01,02,00(done), running stays 1. clear asserted mid-count -> s=00 next cycle, no done pulse.
